// File: rtl/compare_driver.sv
// compare_driver: sequencer feeding the dual-register compare unit.
// Loads each pair, samples the q4/q5 verdict, returns results and run stats.
module compare_driver #(
  parameter int A          = 8,
  parameter int D          = 8,
  parameter int R          = 256,
  parameter int SETTLE_CYC = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [A:0]   count,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [D-1:0] in_data1,
  input  logic [D-1:0] in_data2,
  output logic [D-1:0] data1,
  output logic [D-1:0] data2,
  output logic         select1,
  output logic         select2,
  output logic         reset1,
  output logic         reset2,
  input  logic         q4,
  input  logic         q5,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         res_match,
  output logic [A-1:0] res_index,
  output logic [A:0]   match_cnt,
  output logic [A:0]   mismatch_cnt,
  output logic         first_mis_vld,
  output logic [A-1:0] first_mis_idx,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [A:0] R_MAX = (A+1)'(R);

  typedef enum logic [2:0] {
    IDLE, CLEAR, WAIT_IN, LOAD, SETTLE, SAMPLE, RESULT
  } state_t;

  state_t state, state_nxt;

  logic [A:0]    count_q;
  logic [A-1:0]  index;
  logic [SW-1:0] settle_cnt;
  logic          last;

  assign last = ({1'b0, index} == (count_q - 1'b1));

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start && count != '0) state_nxt = CLEAR;
      CLEAR:   state_nxt = WAIT_IN;
      WAIT_IN: if (in_valid) state_nxt = LOAD;
      LOAD:    state_nxt = SETTLE;
      SETTLE:  if (settle_cnt == SETTLE_LAST) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = RESULT;
      RESULT:  if (res_ready) state_nxt = last ? IDLE : WAIT_IN;
      default: state_nxt = IDLE;
    endcase
  end

  // state-decoded strobes; reset forces the unit clears and masks the rest
  always_comb begin
    in_ready  = 1'b0;
    res_valid = 1'b0;
    select1   = 1'b0;
    select2   = 1'b0;
    reset1    = reset;
    reset2    = reset;
    busy      = 1'b0;
    if (!reset) begin
      busy      = (state != IDLE);
      in_ready  = (state == WAIT_IN);
      res_valid = (state == RESULT);
      select1   = (state == LOAD);
      select2   = (state == LOAD);
      reset1    = (state == CLEAR);
      reset2    = (state == CLEAR);
    end
  end

  // datapath: pair capture, verdict sampling, run statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q       <= '0;
      index         <= '0;
      settle_cnt    <= '0;
      data1         <= '0;
      data2         <= '0;
      res_match     <= 1'b0;
      res_index     <= '0;
      match_cnt     <= '0;
      mismatch_cnt  <= '0;
      first_mis_vld <= 1'b0;
      first_mis_idx <= '0;
      err           <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (count == '0) done <= 1'b1;
            else count_q <= (count > R_MAX) ? R_MAX : count;
          end
        end
        CLEAR: begin
          index         <= '0;
          match_cnt     <= '0;
          mismatch_cnt  <= '0;
          first_mis_vld <= 1'b0;
          first_mis_idx <= '0;
          err           <= 1'b0;
        end
        WAIT_IN: begin
          if (in_valid) begin
            data1 <= in_data1;
            data2 <= in_data2;
          end
        end
        LOAD: settle_cnt <= '0;
        SETTLE: settle_cnt <= settle_cnt + 1'b1;
        SAMPLE: begin
          res_match <= q5;
          res_index <= index;
          if (q5) match_cnt <= match_cnt + 1'b1;
          else    mismatch_cnt <= mismatch_cnt + 1'b1;
          if (!q5 && !first_mis_vld) begin
            first_mis_vld <= 1'b1;
            first_mis_idx <= index;
          end
          if (q4 == q5) err <= 1'b1;
        end
        RESULT: begin
          if (res_ready) begin
            if (last) done <= 1'b1;
            else      index <= index + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
